// File: rtl/iob_vga_timing.sv
// ---------------------------------------------------------------------------
// iob_vga_timing
//   VGA raster timing generator and output stage for the Pong display path.
//   The horizontal and vertical counters are presented to the image memory as
//   pixel_x/pixel_y. The memory returns RGB combinationally. That RGB is
//   sampled on each pixel tick, blanked outside the visible area, and
//   registered together with hsync/vsync, so all pin outputs line up on the
//   same pixel, one pixel after the counters addressed it.
//
// Ports
//   clk         in   1   system clock
//   rst         in   1   asynchronous, active-high reset
//   en          in   1   run enable; low freezes the raster and blanks outputs
//   pix_rgb     in   12  RGB from image memory for current pixel_x/pixel_y
//   pixel_x     out  10  current horizontal count
//   pixel_y     out  10  current vertical count
//   vga_rgb     out  12  registered, blanked RGB
//   vga_hsync   out  1   registered horizontal sync
//   vga_vsync   out  1   registered vertical sync
//   frame_done  out  1   one-clk pulse after the last pixel of each frame
// ---------------------------------------------------------------------------
module iob_vga_timing #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] pix_rgb,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] vga_rgb,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ON    = 1'(SYNC_POL);
  localparam logic       SYNC_OFF   = ~SYNC_ON;

  logic [3:0]  div_cnt_q, div_cnt_d;
  logic [9:0]  h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        frame_done_q, frame_done_d;

  logic tick;
  logic h_wrap;
  logic v_wrap;
  logic active;
  logic hs_raw;
  logic vs_raw;

  always_comb begin
    tick   = en && (div_cnt_q == DIV_LAST);
    h_wrap = (h_cnt_q == H_LAST);
    v_wrap = (v_cnt_q == V_LAST);
    active = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    hs_raw = (h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST);
    vs_raw = (v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST);

    // Divider restarts whenever the raster is paused, so the first tick after
    // en rises always comes a full CLK_DIV clocks later.
    div_cnt_d = (!en || tick) ? 4'd0 : div_cnt_q + 4'd1;

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
      if (h_wrap) begin
        v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
      end
    end

    // Output stage uses the pre-increment counters, giving one pixel of
    // latency that matches the image memory's read of the same position.
    rgb_d        = rgb_q;
    hsync_d      = hsync_q;
    vsync_d      = vsync_q;
    frame_done_d = tick && h_wrap && v_wrap;
    if (!en) begin
      rgb_d   = 12'h000;
      hsync_d = SYNC_OFF;
      vsync_d = SYNC_OFF;
    end else if (tick) begin
      rgb_d   = active ? pix_rgb : 12'h000;
      hsync_d = hs_raw ? SYNC_ON : SYNC_OFF;
      vsync_d = vs_raw ? SYNC_ON : SYNC_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= 4'd0;
      h_cnt_q      <= 10'd0;
      v_cnt_q      <= 10'd0;
      rgb_q        <= 12'h000;
      hsync_q      <= SYNC_OFF;
      vsync_q      <= SYNC_OFF;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      rgb_q        <= rgb_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign pixel_x    = h_cnt_q;
  assign pixel_y    = v_cnt_q;
  assign vga_rgb    = rgb_q;
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_iob_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_iob_vga_timing
//   Scoreboard bench for iob_vga_timing with a shrunken raster so whole frames
//   fit in a short run. The reference model tracks the raster as one linear
//   pixel index over the frame and derives x/y, blanking and sync windows
//   arithmetically from it. Each clock the stimulus process pushes the
//   expected visible state; a monitor pops and compares after every edge.
// ---------------------------------------------------------------------------
module tb_iob_vga_timing;

  localparam int CLK_DIV  = 3;
  localparam int H_ACTIVE = 16;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 4;
  localparam int H_BP     = 3;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int SYNC_POL = 0;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int N_PIX    = H_TOTAL * V_TOTAL;
  localparam logic S_ON   = 1'(SYNC_POL);
  localparam logic S_OFF  = ~S_ON;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic        fd;
  } obs_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] pix_rgb;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] vga_rgb;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        frame_done;

  obs_t exp_q[$];
  int   errors;
  int   checks;
  bit   armed;

  // reference model state
  int          m_pos;
  int          m_phase;
  logic [11:0] m_rgb;
  logic        m_hs;
  logic        m_vs;
  logic        m_fd;

  iob_vga_timing #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC),
    .H_BP(H_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC),
    .V_BP(V_BP), .SYNC_POL(SYNC_POL)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_rgb(pix_rgb),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .vga_rgb(vga_rgb),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_done(frame_done)
  );

  // 10 ns system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends with a report
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic obs_t modelView();
    obs_t o;
    o.x   = 10'(m_pos % H_TOTAL);
    o.y   = 10'(m_pos / H_TOTAL);
    o.rgb = m_rgb;
    o.hs  = m_hs;
    o.vs  = m_vs;
    o.fd  = m_fd;
    return o;
  endfunction

  // Advance the model by one system clock with the given inputs
  task automatic modelStep(input logic r, input logic e, input logic [11:0] c);
    int x;
    int y;
    if (r) begin
      m_pos = 0; m_phase = 0; m_rgb = 12'h000; m_hs = S_OFF; m_vs = S_OFF; m_fd = 1'b0;
    end else if (!e) begin
      m_phase = 0; m_rgb = 12'h000; m_hs = S_OFF; m_vs = S_OFF; m_fd = 1'b0;
    end else if (m_phase == CLK_DIV - 1) begin
      x = m_pos % H_TOTAL;
      y = m_pos / H_TOTAL;
      m_rgb = (x < H_ACTIVE && y < V_ACTIVE) ? c : 12'h000;
      m_hs  = (x >= H_ACTIVE + H_FP && x < H_ACTIVE + H_FP + H_SYNC) ? S_ON : S_OFF;
      m_vs  = (y >= V_ACTIVE + V_FP && y < V_ACTIVE + V_FP + V_SYNC) ? S_ON : S_OFF;
      m_fd  = (m_pos == N_PIX - 1);
      m_pos = (m_pos + 1) % N_PIX;
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
      m_fd = 1'b0;
    end
  endtask

  // Drive one clock of inputs at the falling edge and queue the expectation
  task automatic applyStimulus(input logic r, input logic e, input logic [11:0] c);
    @(negedge clk);
    rst = r;
    en = e;
    pix_rgb = c;
    modelStep(r, e, c);
    exp_q.push_back(modelView());
    armed = 1'b1;
  endtask

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got x=%0d y=%0d rgb=%h hs=%b vs=%b fd=%b, expected x=%0d y=%0d rgb=%h hs=%b vs=%b fd=%b",
               name, $time, act.x, act.y, act.rgb, act.hs, act.vs, act.fd,
               exp.x, exp.y, exp.rgb, exp.hs, exp.vs, exp.fd);
    end
  endtask

  function automatic obs_t dutView();
    obs_t o;
    o = {pixel_x, pixel_y, vga_rgb, vga_hsync, vga_vsync, frame_done};
    return o;
  endfunction

  // Monitor: compare DUT state one unit after every rising edge
  initial begin
    obs_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (armed) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_empty @%0t: got no expectation, required one per clock", $time);
        end else begin
          exp = exp_q.pop_front();
          checkOutput("cycle", dutView(), exp);
        end
      end
    end
  end

  // Stimulus
  initial begin
    obs_t rst_view;
    int   guard;
    errors = 0;
    checks = 0;
    armed = 1'b0;
    rst = 1'b1;
    en = 1'b0;
    pix_rgb = 12'h000;
    m_pos = 0; m_phase = 0; m_rgb = 12'h000; m_hs = S_OFF; m_vs = S_OFF; m_fd = 1'b0;
    rst_view = '{x: 10'd0, y: 10'd0, rgb: 12'h000, hs: S_OFF, vs: S_OFF, fd: 1'b0};

    $display("[TB] reset and idle");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 12'(($urandom)));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 12'(($urandom)));

    $display("[TB] two frames free running, random rgb");
    for (int i = 0; i < 2 * N_PIX * CLK_DIV + 10; i++) applyStimulus(1'b0, 1'b1, 12'($urandom));

    $display("[TB] random enable gaps");
    for (int i = 0; i < 1200; i++)
      applyStimulus(1'b0, ($urandom_range(0, 9) != 0), 12'($urandom));

    $display("[TB] pause at fixed pixel");
    guard = 0;
    while ((m_pos % H_TOTAL) != 10 && guard < 4 * N_PIX * CLK_DIV) begin
      applyStimulus(1'b0, 1'b1, 12'($urandom));
      guard++;
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 12'($urandom));
    for (int i = 0; i < 300; i++) applyStimulus(1'b0, 1'b1, 12'($urandom));

    $display("[TB] asynchronous reset mid-frame");
    @(negedge clk);
    #2;
    rst = 1'b1;
    en = 1'b1;
    #1;
    checkOutput("async_reset", dutView(), rst_view);
    modelStep(1'b1, 1'b1, pix_rgb);
    exp_q.push_back(modelView());
    applyStimulus(1'b1, 1'b1, 12'($urandom));
    for (int i = 0; i < N_PIX * CLK_DIV + 50; i++) applyStimulus(1'b0, 1'b1, 12'($urandom));

    @(posedge clk);
    #3;
    armed = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
